seg_display_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single 8-bit seven-segment display (`SEG`) among up to `NREQ` requesters. Each requester presents a 4-bit hex nibble. The block grants one requester at a time, captures and decodes its nibble, and holds it on the display for a fixed slot of `HOLD` cycles. It sits in `top` between the datapath sources (counter, switches, ALU result, PC) and the `SEG` output.

---
 rtl/seg_display_arbiter.sv | 147 ++++++++++++++
 tb/tb_seg_display_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/seg_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : seg_display_arbiter
//  Brief    : Round-robin arbiter sharing one 8-bit seven-segment display
//             among NREQ nibble requesters; each winner holds the display
//             for HOLD cycles. Define SEG_BLANK_GAP_EN to insert a one-cycle
//             blank gap between consecutive display slots.
//  Revision : 1.0 - initial release
// ============================================================================
module seg_display_arbiter #(
  parameter int NREQ = 4,
  parameter int HOLD = 8
) (
  input  logic                      clk_2,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [4*NREQ-1:0]         data,
  output logic [NREQ-1:0]           gnt,
  output logic [7:0]                SEG,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      busy
);

  localparam int c_OW = $clog2(NREQ);
  localparam int c_CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1
`ifdef SEG_BLANK_GAP_EN
    , S_GAP = 2'd2
`endif
  } state_t;

  state_t            r_state;
  logic [c_OW-1:0]   r_ptr;
  logic [c_CW-1:0]   r_cnt;
  logic [NREQ-1:0]   r_gnt;
  logic [7:0]        r_seg;
  logic [c_OW-1:0]   r_owner;
  logic              r_busy;

  logic              w_any;
  logic [c_OW-1:0]   w_win;
  logic [c_OW-1:0]   w_nxt_ptr;
  logic [3:0]        w_nib;
  logic              w_decide;

  // Hex nibble to segments a..g (bit 0 = a).
  function automatic logic [6:0] f_decode(input logic [3:0] n);
    case (n)
      4'h0: f_decode = 7'h3F;
      4'h1: f_decode = 7'h06;
      4'h2: f_decode = 7'h5B;
      4'h3: f_decode = 7'h4F;
      4'h4: f_decode = 7'h66;
      4'h5: f_decode = 7'h6D;
      4'h6: f_decode = 7'h7D;
      4'h7: f_decode = 7'h07;
      4'h8: f_decode = 7'h7F;
      4'h9: f_decode = 7'h6F;
      4'hA: f_decode = 7'h77;
      4'hB: f_decode = 7'h7C;
      4'hC: f_decode = 7'h39;
      4'hD: f_decode = 7'h5E;
      4'hE: f_decode = 7'h79;
      default: f_decode = 7'h71;
    endcase
  endfunction

  // Find the first active request at or above the pointer, wrapping.
  always_comb begin
    logic [c_OW:0]   w_sum;
    logic [c_OW-1:0] w_pos;
    w_any = 1'b0;
    w_win = '0;
    w_sum = '0;
    w_pos = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = {1'b0, r_ptr} + (c_OW+1)'(i);
      if (w_sum >= (c_OW+1)'(NREQ)) w_sum = w_sum - (c_OW+1)'(NREQ);
      w_pos = w_sum[c_OW-1:0];
      if (!w_any && req[w_pos]) begin
        w_any = 1'b1;
        w_win = w_pos;
      end
    end
  end

  assign w_nxt_ptr = (w_win == c_OW'(NREQ-1)) ? '0 : w_win + c_OW'(1);
  assign w_nib     = data[{w_win, 2'b00} +: 4];

  // With the gap enabled, slot expiry leads to GAP rather than a new decision.
`ifdef SEG_BLANK_GAP_EN
  assign w_decide = (r_state != S_SHOW);
`else
  assign w_decide = (r_state != S_SHOW) || (r_cnt == '0);
`endif

  // Sequencer: arbitration, slot countdown and registered display outputs.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_seg   <= 8'h00;
      r_owner <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_gnt <= '0;
      if (w_decide) begin
        if (w_any) begin
          r_gnt        <= '0;
          r_gnt[w_win] <= 1'b1;
          r_owner      <= w_win;
          r_busy       <= 1'b1;
          r_seg        <= {1'b1, f_decode(w_nib)};
          r_cnt        <= c_CW'(HOLD-1);
          r_ptr        <= w_nxt_ptr;
          r_state      <= S_SHOW;
        end else begin
          // Nobody waiting: keep the last digit visible but drop dp/busy.
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_seg[7] <= 1'b0;
        end
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - c_CW'(1);
      end
`ifdef SEG_BLANK_GAP_EN
      else begin
        r_state <= S_GAP;
        r_seg   <= 8'h00;
        r_busy  <= 1'b0;
      end
`endif
    end
  end

  assign gnt   = r_gnt;
  assign SEG   = r_seg;
  assign owner = r_owner;
  assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_display_arbiter
//  Brief    : Self-checking bench for seg_display_arbiter with a slot-timeline
//             reference model (SEG_BLANK_GAP_EN aware).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg_display_arbiter;

  localparam int NREQ = 4;
  localparam int HOLD = 8;
  localparam int OW   = $clog2(NREQ);

  logic                clk_2 = 1'b0;
  logic                reset = 1'b1;
  logic [NREQ-1:0]     req   = '0;
  logic [4*NREQ-1:0]   data  = '0;
  logic [NREQ-1:0]     gnt;
  logic [7:0]          SEG;
  logic [OW-1:0]       owner;
  logic                busy;

  seg_display_arbiter #(.NREQ(NREQ), .HOLD(HOLD)) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .req   (req),
    .data  (data),
    .gnt   (gnt),
    .SEG   (SEG),
    .owner (owner),
    .busy  (busy)
  );

  // Free-running clock.
  always #5 clk_2 = ~clk_2;

  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: a timeline of slots measured in absolute edge numbers.
  int              cyc      = 0;
  int              next_arb = 1;
  int              slot_end = 0;
  bit              active   = 0;
  int              m_ptr    = 0;
  logic [NREQ-1:0] m_gnt    = '0;
  logic [7:0]      m_seg    = 8'h00;
  int              m_owner  = 0;
  bit              m_busy   = 0;

  int vectors     = 0;
  int miscompares = 0;

  task automatic model_edge(input bit r, input logic [NREQ-1:0] rq, input logic [4*NREQ-1:0] d);
    int k;
    cyc++;
    m_gnt = '0;
    if (r) begin
      m_ptr = 0; m_seg = 8'h00; m_owner = 0; m_busy = 0;
      active = 0; next_arb = cyc + 1;
      return;
    end
    if (cyc < next_arb) return;
`ifdef SEG_BLANK_GAP_EN
    if (active && cyc == slot_end) begin
      m_seg = 8'h00; m_busy = 0; active = 0; next_arb = cyc + 1;
      return;
    end
`endif
    k = -1;
    for (int i = 0; i < NREQ; i++)
      if (k < 0 && rq[(m_ptr + i) % NREQ]) k = (m_ptr + i) % NREQ;
    if (k >= 0) begin
      m_gnt[k] = 1'b1;
      m_owner  = k;
      m_busy   = 1;
      m_seg    = {1'b1, tbl[d[4*k +: 4]]};
      m_ptr    = (k + 1) % NREQ;
      active   = 1;
      slot_end = cyc + HOLD;
      next_arb = cyc + HOLD;
    end else begin
      m_busy   = 0;
      m_seg[7] = 1'b0;
      active   = 0;
      next_arb = cyc + 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Drive one edge's inputs on the falling edge, check just after the rising edge.
  task automatic step(input bit r, input logic [NREQ-1:0] rq, input logic [4*NREQ-1:0] d);
    @(negedge clk_2);
    reset = r;
    req   = rq;
    data  = d;
    model_edge(r, rq, d);
    @(posedge clk_2);
    #1;
    chk("gnt",   32'(gnt),   32'(m_gnt));
    chk("SEG",   32'(SEG),   32'(m_seg));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("busy",  32'(busy),  32'(m_busy));
  endtask

  initial begin
    // Reset, then a long quiet stretch.
    step(1'b1, '0, '0);
    step(1'b1, '0, '0);
    repeat (50) step(1'b0, '0, (4*NREQ)'($urandom));

    // Single grant of nibble A to requester 0, then the slot runs out.
    step(1'b0, 4'b0001, 16'h000A);
    repeat (12) step(1'b0, '0, (4*NREQ)'($urandom));

    // All requesting, nibbles 0..3: round-robin order.
    repeat (44) step(1'b0, 4'b1111, 16'h3210);

    // Two requesters alternating across the wrap point.
    repeat (30) step(1'b0, 4'b1010, (4*NREQ)'($urandom));
    repeat (4)  step(1'b0, '0, '0);

    // Reset three cycles into a slot, then request from requester 2.
    step(1'b0, 4'b0001, 16'h0005);
    repeat (3) step(1'b0, '0, (4*NREQ)'($urandom));
    step(1'b1, 4'b1111, (4*NREQ)'($urandom));
    step(1'b0, 4'b0100, 16'h0C00);
    repeat (10) step(1'b0, '0, (4*NREQ)'($urandom));

    // Randomised traffic with occasional resets and dropped requests.
    repeat (800) begin
      bit r;
      r = ($urandom_range(0, 99) == 0);
      step(r, NREQ'($urandom), (4*NREQ)'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
